// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and widths for the FFT butterfly scheduler
package fft_pkg;

  localparam int R      = 5;
  localparam int N      = 32;
  localparam int HALF   = N / 2;
  localparam int ADDR_W = R;
  localparam int EXP_W  = R - 1;
  localparam int STG_W  = $clog2(R);
  // Drain counter width; BF_LAT is limited to 1..15.
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One slot of the read-to-write delay line.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
  } wr_slot_t;

endpackage

// File: rtl/fft_bf_sched_if.sv
// rtl/fft_bf_sched_if.sv - control and memory-address bundle of the butterfly scheduler
interface fft_bf_sched_if;
  import fft_pkg::*;

  logic              i_start;
  logic              o_busy;
  logic              o_done;
  logic [STG_W-1:0]  o_stage;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr_a;
  logic [ADDR_W-1:0] o_rd_addr_b;
  logic [EXP_W-1:0]  o_exponent;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr_a;
  logic [ADDR_W-1:0] o_wr_addr_b;

  // Scheduler side.
  modport master (
    input  i_start,
    output o_busy, o_done, o_stage,
    output o_rd_en, o_rd_addr_a, o_rd_addr_b, o_exponent,
    output o_wr_en, o_wr_addr_a, o_wr_addr_b
  );

  // FFT control / datapath side.
  modport slave (
    output i_start,
    input  o_busy, o_done, o_stage,
    input  o_rd_en, o_rd_addr_a, o_rd_addr_b, o_exponent,
    input  o_wr_en, o_wr_addr_a, o_wr_addr_b
  );

endinterface

// File: rtl/fft_bf_addr.sv
// rtl/fft_bf_addr.sv - butterfly address pair and twiddle exponent from (b, s)
module fft_bf_addr
  import fft_pkg::*;
(
  input  logic [EXP_W-1:0]  b,
  input  logic [STG_W-1:0]  s,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [EXP_W-1:0]  exponent
);

  logic [STG_W-1:0]  p;
  logic [ADDR_W-1:0] bw;
  logic [ADDR_W-1:0] bit_p;
  logic [ADDR_W-1:0] low_mask;

  // Insert a zero at bit p of b; the partner address sets that bit.
  always_comb begin
    p        = STG_W'(R - 1) - s;
    bw       = {1'b0, b};
    bit_p    = ADDR_W'(1) << p;
    low_mask = bit_p - ADDR_W'(1);
    addr_a   = ((bw & ~low_mask) << 1) | (bw & low_mask);
    addr_b   = addr_a | bit_p;
    exponent = b << s;
  end

endmodule

// File: rtl/fft_bf_sched.sv
// rtl/fft_bf_sched.sv - in-place radix-2 DIF butterfly scheduler with write-back delay line
module fft_bf_sched
  import fft_pkg::*;
#(
  parameter int BF_LAT = 3
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fft_bf_sched_if.master bus
);

  state_t            state;
  state_t            next_state;
  logic [STG_W-1:0]  s;
  logic [EXP_W-1:0]  b;
  logic [CNT_W-1:0]  d;
  logic              rd_en;
  logic              busy;
  logic              done;
  logic              last_bf;
  logic              last_drain;
  logic              last_stage;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [EXP_W-1:0]  exponent;
  wr_slot_t          rd_slot;
  wr_slot_t          pipe [BF_LAT];

  assign last_bf    = (b == EXP_W'(HALF - 1));
  assign last_drain = (d == CNT_W'(BF_LAT - 1));
  assign last_stage = (s == STG_W'(R - 1));

  fft_bf_addr u_addr (
    .b        (b),
    .s        (s),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .exponent (exponent)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode; DRAIN holds off the next stage until its writes have landed.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.i_start) next_state = RUN;
      RUN:     if (last_bf)     next_state = DRAIN;
      DRAIN:   if (last_drain)  next_state = last_stage ? DONE : RUN;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    rd_en = (state == RUN);
    busy  = (state == RUN) || (state == DRAIN);
    done  = (state == DONE);
  end

  // Stage, butterfly and drain counters; stage returns to 0 on the way back to IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s <= '0;
      b <= '0;
      d <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            s <= '0;
            b <= '0;
          end
        end
        RUN: begin
          if (last_bf) d <= '0;
          else         b <= b + EXP_W'(1);
        end
        DRAIN: begin
          d <= d + CNT_W'(1);
          if (last_drain && !last_stage) begin
            s <= s + STG_W'(1);
            b <= '0;
          end
        end
        DONE: begin
          s <= '0;
          b <= '0;
        end
        default: ;
      endcase
    end
  end

  // Read slot entering the delay line; addresses are zero when no read is issued.
  always_comb begin
    rd_slot.en     = rd_en;
    rd_slot.addr_a = rd_en ? addr_a : '0;
    rd_slot.addr_b = rd_en ? addr_b : '0;
  end

  // Write-back delay line; reset drops any reads still in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BF_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= rd_slot;
      for (int i = 1; i < BF_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign bus.o_busy      = busy;
  assign bus.o_done      = done;
  assign bus.o_stage     = s;
  assign bus.o_rd_en     = rd_en;
  assign bus.o_rd_addr_a = rd_slot.addr_a;
  assign bus.o_rd_addr_b = rd_slot.addr_b;
  assign bus.o_exponent  = rd_en ? exponent : '0;
  assign bus.o_wr_en     = pipe[BF_LAT-1].en;
  assign bus.o_wr_addr_a = pipe[BF_LAT-1].addr_a;
  assign bus.o_wr_addr_b = pipe[BF_LAT-1].addr_b;

endmodule

// File: tb/tb_fft_bf_sched.sv
// tb/tb_fft_bf_sched.sv - self-checking bench for fft_bf_sched
module tb_fft_bf_sched;
  import fft_pkg::*;

  localparam int BF_LAT    = 3;
  localparam int STAGE_CYC = HALF + BF_LAT;
  localparam int T_LAST_WR = R * STAGE_CYC;
  localparam int T_DONE    = T_LAST_WR + 1;
  localparam int T_PERIOD  = T_DONE + 1;

  logic i_clk = 1'b0;
  logic i_rst;

  fft_bf_sched_if bus ();

  fft_bf_sched #(.BF_LAT(BF_LAT)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {int cyc; int tr; int stage; int a; int b; int e;} rd_exp_t;
  typedef struct {int cyc; int tr; int stage; int a; int b;} wr_exp_t;
  typedef struct {int cyc; bit rd_en; int a; int b; int e; int stage; bit busy; bit done;} vec_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  vec_t    tbl [10];
  int      seen [2][R][N];
  int      n_assert = 0;
  int      n_fail   = 0;

  task automatic chk(input bit ok, input string name, input string detail);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic zero_chk(input string name);
    logic [63:0] v;
    v = 64'({bus.o_busy, bus.o_done, bus.o_stage, bus.o_rd_en, bus.o_rd_addr_a,
             bus.o_rd_addr_b, bus.o_exponent, bus.o_wr_en, bus.o_wr_addr_a, bus.o_wr_addr_b});
    chk(v == 64'd0, name, $sformatf("outputs got %0h required 0", v));
  endtask

  function automatic int ref_addr_a(input int s, input int b);
    int p;
    p = R - 1 - s;
    return (b / (1 << p)) * (1 << (p + 1)) + (b % (1 << p));
  endfunction

  task automatic load_model(input int ntr);
    for (int t = 0; t < 2; t++)
      for (int s = 0; s < R; s++)
        for (int a = 0; a < N; a++) seen[t][s][a] = 0;
    for (int t = 0; t < ntr; t++)
      for (int s = 0; s < R; s++)
        for (int b = 0; b < HALF; b++) begin
          rd_exp_t e;
          e.cyc   = t * T_PERIOD + 1 + s * STAGE_CYC + b;
          e.tr    = t;
          e.stage = s;
          e.a     = ref_addr_a(s, b);
          e.b     = e.a + (1 << (R - 1 - s));
          e.e     = (b * (1 << s)) % (1 << (R - 1));
          rd_q.push_back(e);
        end
  endtask

  // Runs ncyc cycles after a start request issued in the current cycle.
  task automatic run(input int ncyc, input int ntr, input bit hold, input int rst_at, input bit use_tbl);
    rd_q.delete();
    wr_q.delete();
    load_model(ntr);
    bus.i_start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge i_clk);
      #1;
      if (k == 1 && !hold) bus.i_start = 1'b0;
      if (rst_at > 0 && k == rst_at + 1) begin
        zero_chk("reset_mid_run");
        i_rst = 1'b0;
      end else begin
        bit exp_busy, exp_done;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        for (int t = 0; t < ntr; t++) begin
          if (k >= t * T_PERIOD + 1 && k <= t * T_PERIOD + T_LAST_WR) exp_busy = 1'b1;
          if (k == t * T_PERIOD + T_DONE) exp_done = 1'b1;
        end
        if (rst_at > 0 && k > rst_at) begin
          exp_busy = 1'b0;
          exp_done = 1'b0;
        end
        chk(bus.o_busy == exp_busy && bus.o_done == exp_done, "busy_done",
            $sformatf("cycle %0d busy/done got %0b/%0b required %0b/%0b",
                      k, bus.o_busy, bus.o_done, exp_busy, exp_done));

        if (bus.o_rd_en) begin
          if (rd_q.size() == 0) begin
            chk(1'b0, "unexpected_read", $sformatf("cycle %0d got addrs %0d/%0d required no read",
                k, bus.o_rd_addr_a, bus.o_rd_addr_b));
          end else begin
            rd_exp_t e;
            bit haz;
            e = rd_q.pop_front();
            chk(e.cyc == k && int'(bus.o_stage) == e.stage && int'(bus.o_rd_addr_a) == e.a &&
                int'(bus.o_rd_addr_b) == e.b && int'(bus.o_exponent) == e.e, "read",
                $sformatf("got cycle %0d stage %0d addr %0d/%0d exp %0d required cycle %0d stage %0d addr %0d/%0d exp %0d",
                          k, bus.o_stage, bus.o_rd_addr_a, bus.o_rd_addr_b, bus.o_exponent,
                          e.cyc, e.stage, e.a, e.b, e.e));
            haz = 1'b0;
            foreach (wr_q[i]) if (wr_q[i].tr == e.tr && wr_q[i].stage < e.stage) haz = 1'b1;
            chk(!haz, "raw_hazard", $sformatf("cycle %0d stage %0d read got pending earlier-stage write required none",
                k, e.stage));
            seen[e.tr][e.stage][bus.o_rd_addr_a]++;
            seen[e.tr][e.stage][bus.o_rd_addr_b]++;
            wr_q.push_back('{k + BF_LAT, e.tr, e.stage, int'(bus.o_rd_addr_a), int'(bus.o_rd_addr_b)});
          end
        end else if (rd_q.size() > 0 && rd_q[0].cyc == k) begin
          chk(1'b0, "missing_read", $sformatf("cycle %0d got no read required %0d/%0d",
              k, rd_q[0].a, rd_q[0].b));
          void'(rd_q.pop_front());
        end

        if (bus.o_wr_en) begin
          if (wr_q.size() == 0) begin
            chk(1'b0, "unexpected_write", $sformatf("cycle %0d got addrs %0d/%0d required no write",
                k, bus.o_wr_addr_a, bus.o_wr_addr_b));
          end else begin
            wr_exp_t w;
            w = wr_q.pop_front();
            chk(w.cyc == k && int'(bus.o_wr_addr_a) == w.a && int'(bus.o_wr_addr_b) == w.b, "write",
                $sformatf("got cycle %0d addr %0d/%0d required cycle %0d addr %0d/%0d",
                          k, bus.o_wr_addr_a, bus.o_wr_addr_b, w.cyc, w.a, w.b));
          end
        end else if (wr_q.size() > 0 && wr_q[0].cyc == k) begin
          chk(1'b0, "missing_write", $sformatf("cycle %0d got no write required %0d/%0d",
              k, wr_q[0].a, wr_q[0].b));
          void'(wr_q.pop_front());
        end

        if (use_tbl) begin
          foreach (tbl[i]) begin
            if (tbl[i].cyc == k) begin
              bit ok;
              ok = bus.o_rd_en == tbl[i].rd_en && bus.o_busy == tbl[i].busy &&
                   bus.o_done == tbl[i].done && int'(bus.o_stage) == tbl[i].stage;
              if (tbl[i].rd_en)
                ok = ok && int'(bus.o_rd_addr_a) == tbl[i].a && int'(bus.o_rd_addr_b) == tbl[i].b &&
                     int'(bus.o_exponent) == tbl[i].e;
              chk(ok, $sformatf("vec%0d", i),
                  $sformatf("cycle %0d got rd %0b addr %0d/%0d exp %0d stage %0d busy %0b done %0b required rd %0b addr %0d/%0d exp %0d stage %0d busy %0b done %0b",
                            k, bus.o_rd_en, bus.o_rd_addr_a, bus.o_rd_addr_b, bus.o_exponent,
                            bus.o_stage, bus.o_busy, bus.o_done, tbl[i].rd_en, tbl[i].a, tbl[i].b,
                            tbl[i].e, tbl[i].stage, tbl[i].busy, tbl[i].done));
            end
          end
        end

        if (rst_at > 0 && k == rst_at) begin
          i_rst = 1'b1;
          rd_q.delete();
          wr_q.delete();
        end
      end
    end
    if (hold) bus.i_start = 1'b0;
    if (rst_at == 0) begin
      chk(rd_q.size() == 0 && wr_q.size() == 0, "queues_drained",
          $sformatf("got %0d reads %0d writes outstanding required 0/0", rd_q.size(), wr_q.size()));
      for (int t = 0; t < ntr; t++)
        for (int s = 0; s < R; s++) begin
          bit ok;
          ok = 1'b1;
          for (int a = 0; a < N; a++) if (seen[t][s][a] != 1) ok = 1'b0;
          chk(ok, "addr_once_per_stage", $sformatf("transform %0d stage %0d got some address not read exactly once required each once",
              t, s));
        end
    end
  endtask

  initial begin
    tbl[0] = '{1,  1'b1, 0,  16, 0,  0, 1'b1, 1'b0};
    tbl[1] = '{2,  1'b1, 1,  17, 1,  0, 1'b1, 1'b0};
    tbl[2] = '{16, 1'b1, 15, 31, 15, 0, 1'b1, 1'b0};
    tbl[3] = '{17, 1'b0, 0,  0,  0,  0, 1'b1, 1'b0};
    tbl[4] = '{20, 1'b1, 0,  8,  0,  1, 1'b1, 1'b0};
    tbl[5] = '{29, 1'b1, 17, 25, 2,  1, 1'b1, 1'b0};
    tbl[6] = '{80, 1'b1, 6,  7,  0,  4, 1'b1, 1'b0};
    tbl[7] = '{95, 1'b0, 0,  0,  0,  4, 1'b1, 1'b0};
    tbl[8] = '{96, 1'b0, 0,  0,  0,  4, 1'b0, 1'b1};
    tbl[9] = '{97, 1'b0, 0,  0,  0,  0, 1'b0, 1'b0};

    i_rst       = 1'b1;
    bus.i_start = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    zero_chk("reset_state");
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    run(100, 1, 1'b0, 0, 1'b1);
    run(2 * T_PERIOD, 2, 1'b1, 0, 1'b0);
    run(50, 1, 1'b0, 40, 1'b0);
    run(100, 1, 1'b0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bf_sched.md
# fft_bf_sched

In-place radix-2 DIF FFT butterfly scheduler. It sequences all R stages of N/2 butterflies over a single dual-port sample memory. Each cycle it issues one butterfly's read address pair and twiddle exponent, then replays the same addresses as a write pair BF_LAT cycles later. It sits between the top-level FFT control and the butterfly/twiddle-ROM datapath, and replaces free-running per-butterfly exponent generation with a full start-to-done sequencer.

## Interface
- R, 5, log2 of transform size; stages run 0..R-1
- N, 32, transform size; must equal 2**R
- BF_LAT, 3, cycles from read issue to write-back of the same butterfly; legal range 1..15
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  begin a transform; sampled only in IDLE
- o_busy  out  1  high in RUN and DRAIN
- o_done  out  1  one-cycle pulse when the transform is complete
- o_stage  out  [$clog2(R)-1:0]  stage of the butterfly currently being read
- o_rd_en  out  1  read pair valid this cycle
- o_rd_addr_a / o_rd_addr_b  out  [R-1:0]  upper/lower butterfly read addresses
- o_exponent  out  [R-2:0]  twiddle exponent, aligned with o_rd_en
- o_wr_en  out  1  write pair valid this cycle
- o_wr_addr_a / o_wr_addr_b  out  [R-1:0]  write-back addresses

## Operation
- States: IDLE, RUN, DRAIN, DONE. Counters: stage s (0..R-1), butterfly b (0..N/2-1), drain count d.
- IDLE: if i_start, go to RUN with s=0, b=0. Otherwise stay.
- RUN: o_rd_en=1. If b==N/2-1, go to DRAIN with d=0. Otherwise b++.
- DRAIN: o_rd_en=0; d increments each cycle. When d==BF_LAT-1:
  - if s==R-1, go to DONE;
  - else s++, b=0, go to RUN.
- DONE: o_done=1 for one cycle, then IDLE.
- Address map, with p=R-1-s:
  - o_rd_addr_a = b with a 0 inserted at bit p (bits below p unchanged, bits at/above p shifted up one);
  - o_rd_addr_b = o_rd_addr_a | (1<<p).
- o_exponent = (b << s) mod 2**(R-1), truncated to R-1 bits.
- Write path: a BF_LAT-deep delay line of {rd_en, addr_a, addr_b} drives o_wr_en, o_wr_addr_a and o_wr_addr_b.
- DRAIN exists so that no read of stage s+1 is issued before the last write of stage s lands. This is the read-after-write hazard of in-place operation.
- i_start is ignored outside IDLE, including during DONE.
- Output order is bit-reversed; reordering is not this block's job.

## Timing
- Reset: state=IDLE, s=b=d=0, delay line cleared. All outputs are 0.
- Reset mid-transform aborts immediately. No write is emitted after reset, even if reads were in flight.
- All outputs are decoded from registers. There is no combinational path from i_start to any output.
- i_start is sampled at cycle 0. The first read is at cycle 1.
- Each stage takes N/2 RUN cycles plus BF_LAT DRAIN cycles.
- The last write occurs at cycle R*(N/2+BF_LAT). o_done is high at R*(N/2+BF_LAT)+1. IDLE follows, and a new i_start is accepted in that cycle.
- Each o_wr_en pulse occurs exactly BF_LAT cycles after its o_rd_en pulse, with identical addresses.
- o_rd_en and o_wr_en are both high only inside RUN from cycle BF_LAT+1 of a stage onward. The dual-port memory absorbs this.
- o_stage holds the last read's stage through DRAIN and DONE, and returns to 0 in IDLE.

## Structure
- Shared package fft_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - HALF = N/2;
  - widths ADDR_W = R, EXP_W = R-1, STG_W = $clog2(R).
- One combinational sub-module, fft_bf_addr (inputs b, s; outputs addr_a, addr_b, exponent). The core holds the FSM, counters and write delay line.

## Test plan
Default parameters for all scenarios: N=32, R=5, BF_LAT=3.
- Stage-0 addressing: pulse i_start. Cycle 1 gives rd addrs 0/16, exp 0. Cycle 2 gives 1/17, exp 1. Cycle 16 gives 15/31, exp 15.
- Stage 1 and last stage:
  - in stage 1, b=9 gives rd addrs 17/25, exp 2;
  - in stage 4, b=3 gives rd addrs 6/7, exp 0;
  - the reference model compares every read pair across all 80 butterflies, each address appearing exactly once per stage.
- Write alignment and hazard:
  - every o_wr_en occurs 3 cycles after its read, with matching addresses;
  - no stage-s+1 read comes before the final stage-s write;
  - the first stage-1 read is at cycle 20.
- Completion: the last write is at cycle 95 and o_done pulses at cycle 96 only. o_busy is high from cycles 1 to 95.
- Start handling: i_start held high throughout the run is ignored until IDLE. Back-to-back transforms start with the second first read at cycle 98.
- Reset mid-run: assert i_rst at cycle 40. All outputs are 0 the next cycle, no writes follow, and a fresh i_start restarts at stage 0, b=0.
